// File: rtl/inv_diffusion_if.sv
// ---------------------------------------------------------------------------
// inv_diffusion_if
//   Groups the two valid/ready streams of the inverse AES diffusion block.
//   A state is 16 bytes laid out as [row][col][bit]. Row 3 is the top row.
//   Column 3 is the first column.
//
//   in_valid    producer has a state and last_round flag on the bus
//   in_ready    block can accept a state this cycle
//   in_state    ciphertext-side state, [row][col]
//   last_round  1 = final AES round, skip InvMixColumns
//   out_valid   out_state holds a finished result
//   out_ready   consumer takes out_state on this edge
//   out_state   InvShiftRows(InvMixColumns(in_state)), or InvShiftRows only
//
//   master: producer/consumer side (testbench or surrounding round logic)
//   slave : the inv_diffusion block itself
// ---------------------------------------------------------------------------
interface inv_diffusion_if;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][3:0][7:0]  in_state;
    logic                  last_round;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0][3:0][7:0]  out_state;

    modport master (
        output in_valid,
        output in_state,
        output last_round,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  last_round,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/inv_diffusion.sv
// ---------------------------------------------------------------------------
// inv_diffusion
//   Inverse AES diffusion layer for the decrypt round. The block applies
//   InvMixColumns first, then InvShiftRows, so inv_diffusion(diffusion(x)) == x.
//   It works iteratively: it accepts one state and mixes COLS_PER_CYCLE
//   columns per clock, starting at column 3. It then presents the row-rotated
//   result until the consumer takes it.
//
//   Parameters
//     COLS_PER_CYCLE  columns mixed per clock (1, 2 or 4)
//
//   Ports
//     clk   single clock, all state updates on the rising edge
//     rst   synchronous, active-high reset
//     bus   inv_diffusion_if.slave. It carries the input stream
//           (in_valid/in_ready/in_state/last_round) and the output stream
//           (out_valid/out_ready/out_state).
// ---------------------------------------------------------------------------
module inv_diffusion #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    inv_diffusion_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } state_e;

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    state_e                state_q, state_d;
    logic [3:0][3:0][7:0]  buffer_q, buffer_d;
    logic [1:0]            col_q, col_d;

    logic [3:0][3:0][7:0]  mixed;
    logic [3:0]            colSel;

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1. The larger
    // InvMixColumns constants are built from chains of these.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // InvMixColumns of every column of the buffer. Only the columns picked by
    // colSel are written back on a given MIX edge. This keeps the column
    // walk independent of how many columns are mixed per clock.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[3][c] = mul0e(buffer_q[3][c]) ^ mul0b(buffer_q[2][c])
                        ^ mul0d(buffer_q[1][c]) ^ mul09(buffer_q[0][c]);
            mixed[2][c] = mul09(buffer_q[3][c]) ^ mul0e(buffer_q[2][c])
                        ^ mul0b(buffer_q[1][c]) ^ mul0d(buffer_q[0][c]);
            mixed[1][c] = mul0d(buffer_q[3][c]) ^ mul09(buffer_q[2][c])
                        ^ mul0e(buffer_q[1][c]) ^ mul0b(buffer_q[0][c]);
            mixed[0][c] = mul0b(buffer_q[3][c]) ^ mul0d(buffer_q[2][c])
                        ^ mul09(buffer_q[1][c]) ^ mul0e(buffer_q[0][c]);
        end
    end

    // The columns handled this cycle are col_q down to col_q-COLS_PER_CYCLE+1.
    // The walk starts at 3 and steps by COLS_PER_CYCLE, so it lands exactly
    // on column 0 for every legal parameter value.
    always_comb begin
        colSel = '0;
        for (int c = 0; c < 4; c++) begin
            colSel[c] = (int'(col_q) >= c) && ((int'(col_q) - c) < COLS_PER_CYCLE);
        end
    end

    // Next-state logic for the control FSM and the working buffer.
    // IDLE latches a new state. A final-round state skips straight to DONE
    // because it only needs the row rotation, which is applied on the output
    // side. The buffer is left alone in DONE. This holds out_state stable while
    // the consumer stalls.
    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        col_d    = col_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buffer_d = bus.in_state;
                    col_d    = 2'd3;
                    if (bus.last_round) begin
                        state_d = DONE;
                    end else begin
                        state_d = MIX;
                    end
                end
            end
            MIX: begin
                for (int c = 0; c < 4; c++) begin
                    if (colSel[c]) begin
                        for (int r = 0; r < 4; r++) begin
                            buffer_d[r][c] = mixed[r][c];
                        end
                    end
                end
                col_d = col_q - COL_STEP;
                if (int'(col_q) < COLS_PER_CYCLE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset drops any in-flight state, returns to IDLE and
    // clears the buffer. This makes out_state read as zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            buffer_q <= '0;
            col_q    <= 2'd3;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            col_q    <= col_d;
        end
    end

    // InvShiftRows is pure wiring from the buffer. Row r is rotated right by
    // (3-r) positions, so out[r][k] takes buffer[r][(k+3-r) mod 4].
    always_comb begin
        bus.out_state = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                bus.out_state[r][k] = buffer_q[r][2'(k + 3 - r)];
            end
        end
    end

    // Handshake outputs depend on the state alone. in_ready is also held off
    // while reset is asserted, so no state is accepted into a block being
    // cleared.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
    end

endmodule

// File: tb/tb_inv_diffusion.sv
// ---------------------------------------------------------------------------
// tb_inv_diffusion
//   Directed bench for inv_diffusion. It runs three instances in lock-step
//   (1, 2 and 4 columns per cycle) on the same stimulus. Expected states
//   come from hand-computed vectors and from a forward ShiftRows/MixColumns
//   model used to build round-trip vectors.
// ---------------------------------------------------------------------------
module tb_inv_diffusion;

    typedef logic [3:0][3:0][7:0] state_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    inv_diffusion_if ifMain ();
    inv_diffusion_if if2 ();
    inv_diffusion_if if4 ();

    inv_diffusion #(.COLS_PER_CYCLE(1)) dutMain (.clk(clk), .rst(rst), .bus(ifMain.slave));
    inv_diffusion #(.COLS_PER_CYCLE(2)) dut2    (.clk(clk), .rst(rst), .bus(if2.slave));
    inv_diffusion #(.COLS_PER_CYCLE(4)) dut4    (.clk(clk), .rst(rst), .bus(if4.slave));

    logic   obsValid [3];
    state_t obsState [3];

    assign obsValid[0] = ifMain.out_valid;
    assign obsValid[1] = if2.out_valid;
    assign obsValid[2] = if4.out_valid;
    assign obsState[0] = ifMain.out_state;
    assign obsState[1] = if2.out_state;
    assign obsState[2] = if4.out_state;

    // Single comparison point. Every check is counted here, and a mismatch is
    // reported with its tag.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Forward diffusion model, written from the encrypt-side definitions.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic state_t shiftRows(input state_t b);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                o[r][k] = b[r][2'(k + r + 1)];
        return o;
    endfunction

    function automatic state_t mixColumns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            o[3][c] = xt(s[3][c]) ^ (xt(s[2][c]) ^ s[2][c]) ^ s[1][c] ^ s[0][c];
            o[2][c] = s[3][c] ^ xt(s[2][c]) ^ (xt(s[1][c]) ^ s[1][c]) ^ s[0][c];
            o[1][c] = s[3][c] ^ s[2][c] ^ xt(s[1][c]) ^ (xt(s[0][c]) ^ s[0][c]);
            o[0][c] = (xt(s[3][c]) ^ s[3][c]) ^ s[2][c] ^ s[1][c] ^ xt(s[0][c]);
        end
        return o;
    endfunction

    function automatic state_t diffuse(input state_t x);
        return mixColumns(shiftRows(x));
    endfunction

    function automatic state_t randState();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers one state to all three instances and records each first
    // out_valid cycle and result. It then checks latency and data per instance.
    // Optionally it stalls the main instance in DONE, then releases it.
    task automatic applyStimulus(input state_t s, input logic lr, input state_t expState,
                                 input int holdCycles, input string name);
        int     lat  [3];
        state_t got  [3];
        bit     seen [3];
        int     expLat [3];
        expLat[0] = lr ? 1 : 5;
        expLat[1] = lr ? 1 : 3;
        expLat[2] = lr ? 1 : 2;
        for (int k = 0; k < 3; k++) begin
            lat[k]  = 0;
            got[k]  = '0;
            seen[k] = 1'b0;
        end
        checkOutput({name, "_rdy"}, 128'(ifMain.in_ready), 128'(1));

        ifMain.in_valid = 1'b1; ifMain.in_state = s; ifMain.last_round = lr;
        if2.in_valid    = 1'b1; if2.in_state    = s; if2.last_round    = lr;
        if4.in_valid    = 1'b1; if4.in_state    = s; if4.last_round    = lr;
        @(posedge clk); #1;
        ifMain.in_valid = 1'b0; ifMain.in_state = randState(); ifMain.last_round = ~lr;
        if2.in_valid    = 1'b0; if2.in_state    = randState(); if2.last_round    = ~lr;
        if4.in_valid    = 1'b0; if4.in_state    = randState(); if4.last_round    = ~lr;

        for (int t = 1; t <= 12; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && obsValid[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = t;
                    got[k]  = obsState[k];
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(posedge clk); #1;
        end

        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_lat_c%0d", name, 1 << k), 128'(lat[k]), 128'(expLat[k]));
            checkOutput($sformatf("%s_data_c%0d", name, 1 << k), got[k], expState);
        end

        for (int h = 0; h < holdCycles; h++) begin
            checkOutput({name, "_hold_valid"}, 128'(ifMain.out_valid), 128'(1));
            checkOutput({name, "_hold_rdy"},   128'(ifMain.in_ready),  128'(0));
            checkOutput({name, "_hold_data"},  ifMain.out_state,       expState);
            ifMain.in_valid = 1'b1;
            ifMain.in_state = randState();
            @(posedge clk); #1;
        end

        ifMain.out_ready = 1'b1;
        @(posedge clk); #1;
        ifMain.out_ready = 1'b0;
        ifMain.in_valid  = 1'b0;
        checkOutput({name, "_rel_valid"}, 128'(ifMain.out_valid), 128'(0));
        checkOutput({name, "_rel_rdy"},   128'(ifMain.in_ready),  128'(1));
        checkOutput({name, "_rel_data"},  ifMain.out_state,       expState);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        state_t z;
        ifMain.in_valid = 1'b0; ifMain.in_state = '0; ifMain.last_round = 1'b0; ifMain.out_ready = 1'b0;
        if2.in_valid    = 1'b0; if2.in_state    = '0; if2.last_round    = 1'b0; if2.out_ready    = 1'b1;
        if4.in_valid    = 1'b0; if4.in_state    = '0; if4.last_round    = 1'b0; if4.out_ready    = 1'b1;

        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_rdy",   128'(ifMain.in_ready),  128'(0));
        checkOutput("rst_valid", 128'(ifMain.out_valid), 128'(0));
        checkOutput("rst_data",  ifMain.out_state,       128'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_rdy", 128'(ifMain.in_ready), 128'(1));

        $display("[TB] uniform C6 state");
        applyStimulus({16{8'hC6}}, 1'b0, {16{8'hC6}}, 0, "c6");

        $display("[TB] known InvMixColumns column, with 10-cycle output stall");
        applyStimulus(128'h8E8E8E8E_4D4D4D4D_A1A1A1A1_BCBCBCBC, 1'b0,
                      128'hDBDBDBDB_13131313_53535353_45454545, 10, "col");

        $display("[TB] last round, rotation only");
        applyStimulus(128'h20212223_00010203_30313233_10111213, 1'b1,
                      128'h20212223_03000102_32333031_11121310, 0, "last");

        $display("[TB] reset in second MIX cycle");
        z = randState();
        ifMain.in_valid = 1'b1; ifMain.in_state = diffuse(z); ifMain.last_round = 1'b0;
        @(posedge clk); #1;
        ifMain.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rdy_low", 128'(ifMain.in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_valid", 128'(ifMain.out_valid), 128'(0));
        checkOutput("midrst_rdy",   128'(ifMain.in_ready),  128'(1));
        checkOutput("midrst_data",  ifMain.out_state,       128'(0));
        @(posedge clk); #1;
        z = randState();
        applyStimulus(diffuse(z), 1'b0, z, 0, "after_rst");

        $display("[TB] random round trips");
        for (int i = 0; i < 1000; i++) begin
            z = randState();
            if ((i % 10) == 9) begin
                applyStimulus(shiftRows(z), 1'b1, z, 0, $sformatf("rnd%0d_last", i));
            end else begin
                applyStimulus(diffuse(z), 1'b0, z, 0, $sformatf("rnd%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
